// File: rtl/glitch_cmd_ctrl.sv
// glitch_cmd_ctrl
// Byte-level command sequencer between the host UART receiver and the glitch
// engine. It parses the host byte stream into two frame kinds:
//   - 0x00, opcode [, arg] : command frames (config writes, arm, resets)
//   - n (n != 0), n bytes  : passthrough frames forwarded to the target UART
//
// Ports:
//   clk, rst               system clock, async active-high reset
//   rx_data/rx_valid       host byte stream (one-cycle strobe, no back-pressure)
//   pt_data/pt_valid/pt_rdy passthrough byte to target UART (ready/valid)
//   cfg_width/pulses/delay glitch configuration registers
//   glitch_arm/glitch_done arm level to the engine, cleared by done strobe
//   o_board_rst            target-board reset pulse, RST_CYCLES long
//   sys_rst_req            one-cycle full FPGA reset request
//   overrun, bad_cmd       sticky error flags, cleared only by rst
module glitch_cmd_ctrl #(
    parameter int unsigned RST_CYCLES = 1000,
    parameter logic [7:0]  WIDTH_DEF  = 8'd1,
    parameter logic [7:0]  PULSES_DEF = 8'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  pt_data,
    output logic        pt_valid,
    input  logic        pt_rdy,
    output logic [7:0]  cfg_width,
    output logic [7:0]  cfg_pulses,
    output logic [31:0] cfg_delay,
    output logic        glitch_arm,
    input  logic        glitch_done,
    output logic        o_board_rst,
    output logic        sys_rst_req,
    output logic        overrun,
    output logic        bad_cmd
);

    typedef enum logic [1:0] {IDLE, OPC, ARG, PASS} state_t;

    state_t      state, state_nxt;
    logic [7:0]  len, len_nxt;
    logic [7:0]  opc;
    logic [31:0] rst_cnt;

    logic set_opc, wr_width, wr_pulses, wr_delay;
    logic set_arm, set_brst, set_sysrst, set_bad;
    logic pt_load, pt_drop;

    // Holding register stays full across this edge only if it is valid and
    // not being taken; a byte landing on the handshake edge is not an overrun.
    logic pt_busy;
    assign pt_busy = pt_valid && !pt_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            len   <= 8'd0;
        end else begin
            state <= state_nxt;
            len   <= len_nxt;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_nxt  = state;
        len_nxt    = len;
        set_opc    = 1'b0;
        wr_width   = 1'b0;
        wr_pulses  = 1'b0;
        wr_delay   = 1'b0;
        set_arm    = 1'b0;
        set_brst   = 1'b0;
        set_sysrst = 1'b0;
        set_bad    = 1'b0;
        pt_load    = 1'b0;
        pt_drop    = 1'b0;
        if (rx_valid) begin
            case (state)
                IDLE: begin
                    if (rx_data == 8'h00) begin
                        state_nxt = OPC;
                    end else begin
                        len_nxt   = rx_data;
                        state_nxt = PASS;
                    end
                end
                OPC: begin
                    state_nxt = IDLE;
                    case (rx_data)
                        8'hFF: set_sysrst = 1'b1;
                        8'hFE: set_brst   = 1'b1;
                        8'hFC: set_arm    = 1'b1;
                        8'h10, 8'h11, 8'h20, 8'h21, 8'h22, 8'h23: begin
                            set_opc   = 1'b1;
                            state_nxt = ARG;
                        end
                        default: set_bad = 1'b1;
                    endcase
                end
                ARG: begin
                    state_nxt = IDLE;
                    // Only the six argument opcodes can be latched, so the
                    // default arm covers 0x20..0x23.
                    case (opc)
                        8'h10:   wr_width  = 1'b1;
                        8'h11:   wr_pulses = 1'b1;
                        default: wr_delay  = 1'b1;
                    endcase
                end
                PASS: begin
                    if (pt_busy) pt_drop = 1'b1;
                    else         pt_load = 1'b1;
                    // Dropped bytes still count so framing stays aligned.
                    len_nxt = len - 8'd1;
                    if (len == 8'd1) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opc         <= 8'd0;
            cfg_width   <= WIDTH_DEF;
            cfg_pulses  <= PULSES_DEF;
            cfg_delay   <= 32'd0;
            pt_data     <= 8'd0;
            pt_valid    <= 1'b0;
            glitch_arm  <= 1'b0;
            o_board_rst <= 1'b0;
            rst_cnt     <= 32'd0;
            sys_rst_req <= 1'b0;
            overrun     <= 1'b0;
            bad_cmd     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // pre-edge values regardless of statement order.
            if (set_opc)   opc        <= rx_data;
            if (wr_width)  cfg_width  <= rx_data;
            if (wr_pulses) cfg_pulses <= rx_data;
            if (wr_delay)  cfg_delay[{opc[1:0], 3'b000} +: 8] <= rx_data;

            if (pt_load) begin
                pt_data  <= rx_data;
                pt_valid <= 1'b1;
            end else if (pt_valid && pt_rdy) begin
                pt_valid <= 1'b0;
            end

            // Arm request wins over a simultaneous done strobe.
            if (set_arm)          glitch_arm <= 1'b1;
            else if (glitch_done) glitch_arm <= 1'b0;

            // rst_cnt holds the remaining high cycles after the current one;
            // a new request reloads it, extending the pulse.
            if (set_brst) begin
                o_board_rst <= 1'b1;
                rst_cnt     <= 32'(RST_CYCLES - 1);
            end else if (o_board_rst) begin
                if (rst_cnt == 32'd0) o_board_rst <= 1'b0;
                else                  rst_cnt     <= rst_cnt - 32'd1;
            end

            sys_rst_req <= set_sysrst;
            if (pt_drop) overrun <= 1'b1;
            if (set_bad) bad_cmd <= 1'b1;
        end
    end

endmodule

// File: tb/tb_glitch_cmd_ctrl.sv
// Self-checking bench for glitch_cmd_ctrl. Passthrough bytes are pushed to a
// scoreboard queue when sent and compared when the DUT hands them over.
module tb_glitch_cmd_ctrl;

    logic        tb_clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  pt_data;
    logic        pt_valid;
    logic        pt_rdy;
    logic [7:0]  cfg_width;
    logic [7:0]  cfg_pulses;
    logic [31:0] cfg_delay;
    logic        glitch_arm;
    logic        glitch_done;
    logic        o_board_rst;
    logic        sys_rst_req;
    logic        overrun;
    logic        bad_cmd;

    int n_tests = 0;
    int n_fail  = 0;
    int hi_cnt  = 0;
    logic [7:0] sb_q[$];

    glitch_cmd_ctrl #(
        .RST_CYCLES(1000),
        .WIDTH_DEF (8'd1),
        .PULSES_DEF(8'd0)
    ) dut (
        .clk        (tb_clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .pt_data    (pt_data),
        .pt_valid   (pt_valid),
        .pt_rdy     (pt_rdy),
        .cfg_width  (cfg_width),
        .cfg_pulses (cfg_pulses),
        .cfg_delay  (cfg_delay),
        .glitch_arm (glitch_arm),
        .glitch_done(glitch_done),
        .o_board_rst(o_board_rst),
        .sys_rst_req(sys_rst_req),
        .overrun    (overrun),
        .bad_cmd    (bad_cmd)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Tasks start and end 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge tb_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge tb_clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic wait_brst_low();
        int n = 0;
        while (o_board_rst && n < 3000) begin
            tick(1);
            n++;
        end
    endtask

    // Handshake seen at the falling edge completes on the next rising edge.
    always @(negedge tb_clk) begin
        if (o_board_rst) hi_cnt++;
        if (!rst && pt_valid && pt_rdy) begin
            if (sb_q.size() == 0) check("pt_extra", 32'(sb_q.size()), 32'd1);
            else                  check("pt_data", {24'd0, pt_data}, {24'd0, sb_q.pop_front()});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        string msg;
        int    base;
        msg         = "Synchronized";
        rst         = 1'b1;
        rx_data     = 8'h00;
        rx_valid    = 1'b0;
        pt_rdy      = 1'b1;
        glitch_done = 1'b0;
        tick(3);

        // Reset values
        check("rst_pt_valid", {31'd0, pt_valid}, 32'd0);
        check("rst_pt_data",  {24'd0, pt_data}, 32'd0);
        check("rst_width",    {24'd0, cfg_width}, 32'd1);
        check("rst_pulses",   {24'd0, cfg_pulses}, 32'd0);
        check("rst_delay",    cfg_delay, 32'd0);
        check("rst_flags",    {27'd0, glitch_arm, o_board_rst, sys_rst_req, overrun, bad_cmd}, 32'd0);
        rst = 1'b0;
        tick(2);

        // Config writes with 1-cycle latency
        send_byte(8'h00); send_byte(8'h10);
        check("width_pre", {24'd0, cfg_width}, 32'd1);
        send_byte(8'h02);
        check("width", {24'd0, cfg_width}, 32'd2);
        send_byte(8'h00); send_byte(8'h11); send_byte(8'h07);
        check("pulses7", {24'd0, cfg_pulses}, 32'd7);
        send_byte(8'h00); send_byte(8'h11); send_byte(8'h00);
        check("pulses0", {24'd0, cfg_pulses}, 32'd0);
        send_byte(8'h00); send_byte(8'h20); send_byte(8'hC8);
        send_byte(8'h00); send_byte(8'h23); send_byte(8'h01);
        check("delay", cfg_delay, 32'h0100_00C8);
        send_byte(8'h00); send_byte(8'h21); send_byte(8'hAB);
        check("delay_b1", cfg_delay, 32'h0100_ABC8);

        // Board reset pulse, then an extended pulse
        base = hi_cnt;
        send_byte(8'h00); send_byte(8'hFE);
        check("brst_rise", {31'd0, o_board_rst}, 32'd1);
        wait_brst_low();
        check("brst_len", 32'(hi_cnt - base), 32'd1000);
        tick(5);
        base = hi_cnt;
        send_byte(8'h00); send_byte(8'hFE);
        tick(398);
        send_byte(8'h00); send_byte(8'hFE);
        wait_brst_low();
        check("brst_ext_len", 32'(hi_cnt - base), 32'd1400);

        // Glitch arm
        send_byte(8'h00); send_byte(8'hFC);
        check("arm_set", {31'd0, glitch_arm}, 32'd1);
        send_byte(8'h00); send_byte(8'hFC);
        tick(48);
        check("arm_hold", {31'd0, glitch_arm}, 32'd1);
        glitch_done = 1'b1; tick(1); glitch_done = 1'b0;
        check("arm_clr", {31'd0, glitch_arm}, 32'd0);
        tick(2);
        check("arm_no_requeue", {31'd0, glitch_arm}, 32'd0);
        send_byte(8'h00);
        glitch_done = 1'b1; send_byte(8'hFC); glitch_done = 1'b0;
        check("arm_set_wins_idle", {31'd0, glitch_arm}, 32'd1);
        send_byte(8'h00);
        glitch_done = 1'b1; send_byte(8'hFC); glitch_done = 1'b0;
        check("arm_set_wins_armed", {31'd0, glitch_arm}, 32'd1);
        glitch_done = 1'b1; tick(1); glitch_done = 1'b0;
        check("arm_clr2", {31'd0, glitch_arm}, 32'd0);

        // Passthrough, back-to-back, pt_rdy high
        pt_rdy = 1'b1;
        send_byte(8'h0E);
        for (int i = 0; i < 14; i++) begin
            logic [7:0] b;
            if (i < 12)       b = msg[i];
            else if (i == 12) b = 8'h0D;
            else              b = 8'h0A;
            sb_q.push_back(b);
            send_byte(b);
        end
        tick(3);
        check("pt_drained", 32'(sb_q.size()), 32'd0);
        check("pt_no_overrun", {31'd0, overrun}, 32'd0);
        send_byte(8'h00); send_byte(8'hFF);
        check("sysrst_hi", {31'd0, sys_rst_req}, 32'd1);
        tick(1);
        check("sysrst_lo", {31'd0, sys_rst_req}, 32'd0);

        // Overrun with pt_rdy low
        pt_rdy = 1'b0;
        sb_q.push_back(8'h41);
        send_byte(8'h02); send_byte(8'h41); send_byte(8'h42);
        tick(2);
        check("ovr_hold_data", {24'd0, pt_data}, 32'h41);
        check("ovr_hold_valid", {31'd0, pt_valid}, 32'd1);
        check("ovr_flag", {31'd0, overrun}, 32'd1);
        send_byte(8'h00); send_byte(8'h55);
        check("bad_cmd", {31'd0, bad_cmd}, 32'd1);
        check("bad_no_cfg", {cfg_width, cfg_pulses, cfg_delay[15:0]}, {8'h02, 8'h00, 16'hABC8});
        pt_rdy = 1'b1;
        tick(3);
        check("ovr_drained", 32'(sb_q.size()), 32'd0);
        check("ovr_sticky", {31'd0, overrun}, 32'd1);

        // Reset mid-frame
        pt_rdy = 1'b0;
        send_byte(8'h00); send_byte(8'hFC);
        send_byte(8'h00); send_byte(8'hFE);
        send_byte(8'h03); send_byte(8'h41);
        rst = 1'b1;
        #1;
        check("mrst_pt", {23'd0, pt_valid, pt_data}, 32'd0);
        check("mrst_cfg", {cfg_width, cfg_pulses, 16'd0}, {8'h01, 8'h00, 16'd0});
        check("mrst_delay", cfg_delay, 32'd0);
        check("mrst_flags", {27'd0, glitch_arm, o_board_rst, sys_rst_req, overrun, bad_cmd}, 32'd0);
        tick(1);
        rst = 1'b0;
        pt_rdy = 1'b1;
        send_byte(8'h00); send_byte(8'h10); send_byte(8'h09);
        check("post_rst_width", {24'd0, cfg_width}, 32'd9);
        tick(3);
        check("post_rst_quiet", {30'd0, pt_valid, o_board_rst}, 32'd0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/glitch_cmd_ctrl.md
# glitch_cmd_ctrl

Byte-level command sequencer between the host-side UART receiver and the glitch engine. It parses the host stream into two kinds of frame. Command frames are 0x00 followed by an opcode and, for some opcodes, one argument byte. Length-prefixed passthrough frames carry bytes destined for the target UART. The block holds the glitch configuration registers (width, pulse count, 32-bit delay), sequences arm and reset requests to the engine and the target board, and forwards passthrough bytes with a ready/valid handshake.

## Interface
Parameters:
- RST_CYCLES, 1000: length of the o_board_rst pulse in clk cycles (≥1).
- WIDTH_DEF, 8'd1: reset value of cfg_width.
- PULSES_DEF, 8'd0: reset value of cfg_pulses.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  byte from host UART receiver.
- rx_valid  in  1  one-cycle strobe; rx_data is valid.
- pt_data  out  8  passthrough byte to target UART transmitter.
- pt_valid  out  1  pt_data is held valid until accepted.
- pt_rdy  in  1  transmitter accepts pt_data when pt_valid && pt_rdy.
- cfg_width  out  8  glitch pulse width.
- cfg_pulses  out  8  glitch pulse count.
- cfg_delay  out  32  glitch delay in cycles.
- glitch_arm  out  1  level; requests the engine to fire.
- glitch_done  in  1  one-cycle strobe from the engine; clears glitch_arm.
- o_board_rst  out  1  target-board reset pulse.
- sys_rst_req  out  1  one-cycle request for a full FPGA reset.
- overrun  out  1  sticky; a passthrough byte was dropped.
- bad_cmd  out  1  sticky; an unknown opcode was received.

## Operation
- FSM states: IDLE, OPC, ARG, PASS. All transitions occur only on rx_valid.
- IDLE
  - 0x00 -> OPC.
  - Any other value n -> load len = n, go to PASS.
- OPC: decode rx_data.
  - 0xFF: pulse sys_rst_req, -> IDLE.
  - 0xFE: start the board reset pulse, -> IDLE.
  - 0xFC: set glitch_arm, -> IDLE.
  - 0x10, 0x11, 0x20–0x23: latch opcode, -> ARG.
  - Any other opcode: set bad_cmd, -> IDLE.
- ARG: write rx_data to the register selected by the latched opcode, then -> IDLE.
  - 0x10 -> cfg_width.
  - 0x11 -> cfg_pulses.
  - 0x20+k -> cfg_delay[8k+7:8k]; byte 0 is the LSB, and the other delay bytes are unchanged.
- PASS: each byte is forwarded to the pt_* holding register and len is decremented. At len == 0 after the decrement, -> IDLE.
  - If the holding register is still full when a new byte arrives, drop the byte, set overrun, and decrement len anyway so framing stays aligned.
- glitch_arm:
  - Stays set until glitch_done.
  - If 0xFC and glitch_done occur in the same cycle, the set wins.
  - A repeated 0xFC while armed has no effect.
- Board reset:
  - o_board_rst goes high for exactly RST_CYCLES cycles.
  - A new 0xFE during the pulse reloads the counter, which extends the pulse.
- overrun and bad_cmd clear only on rst.

## Timing
- Reset values:
  - FSM state IDLE.
  - pt_valid 0, pt_data 0.
  - cfg_width = WIDTH_DEF, cfg_pulses = PULSES_DEF, cfg_delay = 0.
  - glitch_arm, o_board_rst, sys_rst_req, overrun, bad_cmd all 0.
- All outputs are registered. Every effect appears on the clk edge after the edge that samples rx_valid (1-cycle latency). This covers:
  - config writes;
  - glitch_arm rising;
  - o_board_rst rising;
  - sys_rst_req, which is high for exactly that one cycle;
  - pt_valid rising.
- Passthrough handshake:
  - pt_valid falls on the edge after pt_valid && pt_rdy.
  - If a new byte is loaded on the same edge as the transfer, pt_valid stays high with the new data. A byte arriving on the handshake cycle is therefore not an overrun.
- glitch_arm falls on the edge after glitch_done.
- The block imposes no back-pressure on rx. It must accept rx_valid on any cycle, including back-to-back cycles.
- rst asserted mid-frame aborts the frame and returns all state to the reset values. The bytes that follow are parsed from IDLE.

## Test plan
- Stream 00 10 02, then 00 11 00 -> cfg_width = 0x02, cfg_pulses = 0x00, each one cycle after its argument strobe; state returns to IDLE.
- Stream 00 20 C8, then 00 23 01 -> cfg_delay = 0x010000C8.
- Stream 00 FE with RST_CYCLES = 1000 -> o_board_rst high for exactly 1000 cycles.
  - Resend 00 FE 400 cycles into the pulse -> total high time 1400 cycles.
- Stream 00 FC -> glitch_arm = 1.
  - Pulse glitch_done 50 cycles later -> glitch_arm = 0 on the next edge.
  - Simultaneous 0xFC strobe and glitch_done -> glitch_arm stays 1.
- Stream 0E followed by "Synchronized\r\n", with pt_rdy tied high -> 14 bytes appear on pt_data in order and the FSM returns to IDLE.
  - The next 00 FF -> sys_rst_req high for 1 cycle.
- Stream 02 41 42 with pt_rdy held low -> pt_data = 0x41 held, overrun = 1, FSM in IDLE.
  - Then stream 00 55 -> bad_cmd = 1 and no config change.
  - Assert rst mid-frame (after 03 41) -> all reset values restored.
